// File: rtl/rx_packet_drop_fifo_pkg.sv
// rtl/rx_packet_drop_fifo_pkg.sv - FIFO word layout, write FSM encoding and counter helper
package rx_packet_drop_fifo_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int WORD_W = DATA_W + KEEP_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rx_pkt_sdp_ram.sv
// rtl/rx_pkt_sdp_ram.sv - simple dual-port RAM with 1-cycle registered read
module rx_pkt_sdp_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 73
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Read data holds while i_re is low, so an unconsumed word can wait here.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rx_packet_drop_fifo.sv
// rtl/rx_packet_drop_fifo.sv - store-and-forward RX FIFO dropping bad/overflowed frames (RX_DROP_STATS_EN adds counters)
module rx_packet_drop_fifo
    import rx_packet_drop_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2      = 9,
    parameter int MAX_FRAME_WORDS = 190
) (
    input  logic              clk156,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [DEPTH_LOG2:0] fifo_level
`ifdef RX_DROP_STATS_EN
    ,
    output logic [31:0]       drop_bad_cnt,
    output logic [31:0]       drop_ovf_cnt,
    output logic [31:0]       good_cnt
`endif
);

    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int BEAT_W = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [PTR_W-1:0] FIFO_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    wr_state_t          r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr, r_wr_commit, r_rd_ptr, r_raddr;
    logic [PTR_W-1:0]   w_wr_ptr_nxt, w_commit_nxt;
    logic [BEAT_W-1:0]  r_beats, w_beats_nxt;
    logic               w_we, w_good, w_bad, w_ovf, w_full, w_too_long;
    logic               r_rd_pend, r_out_valid, w_re, w_load_out, w_handshake;
    logic [WORD_W-1:0]  r_out_word, w_rdata;

    assign w_full     = (r_wr_ptr - r_rd_ptr) == FIFO_DEPTH;
    assign w_too_long = (r_beats == BEAT_W'(MAX_FRAME_WORDS));

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_wr_commit;
        w_beats_nxt  = r_beats;
        w_we         = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        w_ovf        = 1'b0;
        case (r_state)
            ST_IDLE, ST_WRITE: begin
                if (s_axis_tvalid) begin
                    // Overflow wins over tuser so a dropped frame bumps exactly one counter.
                    if (w_full || w_too_long) begin
                        w_ovf        = 1'b1;
                        w_wr_ptr_nxt = r_wr_commit;
                        w_beats_nxt  = '0;
                        w_state_nxt  = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        w_we = 1'b1;
                        if (!s_axis_tlast) begin
                            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                            w_beats_nxt  = r_beats + BEAT_W'(1);
                            w_state_nxt  = ST_WRITE;
                        end else if (s_axis_tuser) begin
                            w_bad        = 1'b1;
                            w_wr_ptr_nxt = r_wr_commit;
                            w_beats_nxt  = '0;
                            w_state_nxt  = ST_IDLE;
                        end else begin
                            w_good       = 1'b1;
                            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                            w_commit_nxt = r_wr_ptr + PTR_W'(1);
                            w_beats_nxt  = '0;
                            w_state_nxt  = ST_IDLE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_rd_ptr counts words handed downstream; r_raddr runs ahead by the prefetched words.
    assign w_handshake = r_out_valid & m_axis_tready;
    assign w_load_out  = r_rd_pend & (~r_out_valid | m_axis_tready);
    assign w_re        = (r_raddr != r_wr_commit) & (~r_rd_pend | w_load_out);

    always_ff @(posedge clk156) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_raddr     <= '0;
            r_beats     <= '0;
            r_rd_pend   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_commit <= w_commit_nxt;
            r_beats     <= w_beats_nxt;
            if (w_re)
                r_raddr <= r_raddr + PTR_W'(1);
            if (w_handshake)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_rd_pend   <= w_re | (r_rd_pend & ~w_load_out);
            r_out_valid <= w_load_out | (r_out_valid & ~m_axis_tready);
            if (w_load_out)
                r_out_word <= w_rdata;
        end
    end

    rx_pkt_sdp_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk     (clk156),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .i_re    (w_re),
        .i_raddr (r_raddr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

    assign s_axis_tready = 1'b1;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_word[DATA_W-1:0];
    assign m_axis_tkeep  = r_out_word[DATA_W +: KEEP_W];
    assign m_axis_tlast  = r_out_word[WORD_W-1];
    assign fifo_level    = r_wr_commit - r_rd_ptr;

`ifdef RX_DROP_STATS_EN
    logic [31:0] r_bad_cnt, r_ovf_cnt, r_good_cnt;

    always_ff @(posedge clk156) begin
        if (reset) begin
            r_bad_cnt  <= '0;
            r_ovf_cnt  <= '0;
            r_good_cnt <= '0;
        end else begin
            if (w_bad)
                r_bad_cnt <= sat_inc(r_bad_cnt);
            if (w_ovf)
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            if (w_good)
                r_good_cnt <= sat_inc(r_good_cnt);
        end
    end

    assign drop_bad_cnt = r_bad_cnt;
    assign drop_ovf_cnt = r_ovf_cnt;
    assign good_cnt     = r_good_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{w_good, w_bad, w_ovf};
`endif

endmodule

// File: tb/tb_rx_packet_drop_fifo.sv
// tb/tb_rx_packet_drop_fifo.sv - randomized self-checking bench with a frame-level reference model
module tb_rx_packet_drop_fifo;

    localparam int MAX_W   = 190;
    localparam int B_DEPTH = 16;

    logic        clk156 = 1'b0;
    logic        reset;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tuser;
    logic        m_tready;

    logic        a_sready, a_tvalid, a_tlast;
    logic [63:0] a_tdata;
    logic [7:0]  a_tkeep;
    logic [9:0]  a_level;
    logic        b_sready, b_tvalid, b_tlast;
    logic [63:0] b_tdata;
    logic [7:0]  b_tkeep;
    logic [4:0]  b_level;
`ifdef RX_DROP_STATS_EN
    logic [31:0] a_bad, a_ovf, a_good, b_bad, b_ovf, b_good;
`endif

    always #5 clk156 = ~clk156;

    rx_packet_drop_fifo #(.DEPTH_LOG2(9), .MAX_FRAME_WORDS(MAX_W)) dut_a (
        .clk156(clk156), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(a_sready),
        .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid),
        .m_axis_tlast(a_tlast), .m_axis_tready(m_tready), .fifo_level(a_level)
`ifdef RX_DROP_STATS_EN
        , .drop_bad_cnt(a_bad), .drop_ovf_cnt(a_ovf), .good_cnt(a_good)
`endif
    );

    rx_packet_drop_fifo #(.DEPTH_LOG2(4), .MAX_FRAME_WORDS(MAX_W)) dut_b (
        .clk156(clk156), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(b_sready),
        .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
        .m_axis_tlast(b_tlast), .m_axis_tready(m_tready), .fifo_level(b_level)
`ifdef RX_DROP_STATS_EN
        , .drop_bad_cnt(b_bad), .drop_ovf_cnt(b_ovf), .good_cnt(b_good)
`endif
    );

    int          n_tests, n_fail;
    logic [72:0] exp_q[$];
    logic [72:0] exp_b[$];
    int          exp_good, exp_bad, exp_ovf, exp_b_ovf, b_stored;
    bit          b_track, mon_en, mon_b_en, rand_rdy, prev_stall;
    int          out_beats, out_b;
    logic [72:0] prev_word;

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk156);
        #1;
    endtask

    always @(negedge clk156) begin
        logic [72:0] w;
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", 73'(a_tvalid), 73'(1));
                check("stall_word", {a_tlast, a_tkeep, a_tdata}, prev_word);
            end
            if (a_tvalid && m_tready) begin
                w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("beat", {a_tlast, a_tkeep, a_tdata}, w);
                out_beats++;
            end
            prev_stall = a_tvalid && !m_tready;
            prev_word  = {a_tlast, a_tkeep, a_tdata};
        end else begin
            prev_stall = 1'b0;
        end
        if (mon_b_en && b_tvalid && m_tready) begin
            w = (exp_b.size() > 0) ? exp_b.pop_front() : 'x;
            check("b_beat", {b_tlast, b_tkeep, b_tdata}, w);
            out_b++;
        end
    end

    always begin
        @(posedge clk156);
        #1;
        if (rand_rdy)
            m_tready = ($urandom_range(0, 99) < 60);
    end

    task automatic clear_model();
        exp_q.delete();
        exp_b.delete();
        exp_good = 0; exp_bad = 0; exp_ovf = 0; exp_b_ovf = 0; b_stored = 0;
    endtask

    task automatic do_reset();
        mon_en = 0;
        reset = 1; s_tvalid = 0;
        step(); step();
        reset = 0;
        clear_model();
        mon_en = 1;
    endtask

    // Frame-level model: a frame is output iff it fits and is neither too long nor bad.
    task automatic send_frame(input int len, input bit bad, input int idle_pct);
        logic [72:0] beats[$];
        logic [63:0] d;
        logic [7:0]  k;
        bit          last;
        for (int i = 0; i < len; i++) begin
            while (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
                s_tvalid = 0;
                step();
            end
            last = (i == len - 1);
            d = {$urandom, $urandom};
            k = last ? 8'($urandom_range(1, 255)) : 8'hFF;
            s_tdata = d; s_tkeep = k; s_tlast = last;
            s_tuser = last ? bad : 1'($urandom_range(0, 1));
            s_tvalid = 1;
            beats.push_back({last, k, d});
            if (last) begin
                if (len > MAX_W) exp_ovf++;
                else if (bad) exp_bad++;
                else begin
                    exp_good++;
                    foreach (beats[j]) exp_q.push_back(beats[j]);
                end
                if (b_track) begin
                    if (len > MAX_W || b_stored + len > B_DEPTH) exp_b_ovf++;
                    else if (!bad) begin
                        b_stored += len;
                        foreach (beats[j]) exp_b.push_back(beats[j]);
                    end
                end
            end
            step();
        end
        s_tvalid = 0;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp_b.size() != 0) && k < budget) begin
            step();
            k++;
        end
        check("drain_left", 73'(exp_q.size() + exp_b.size()), 73'(0));
        repeat (3) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start;
        n_tests = 0; n_fail = 0; out_beats = 0; out_b = 0;
        mon_en = 0; mon_b_en = 0; rand_rdy = 0; b_track = 0; prev_stall = 0;
        reset = 1; s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tuser = 0;
        m_tready = 1;
        clear_model();
        step(); step(); step();
        check("rst_tvalid", 73'(a_tvalid), 73'(0));
        check("rst_level", 73'(a_level), 73'(0));
        check("rst_word", {a_tlast, a_tkeep, a_tdata}, 73'(0));
        check("rst_sready", 73'(a_sready), 73'(1));
`ifdef RX_DROP_STATS_EN
        check("rst_cnts", {a_bad[23:0], a_ovf[23:0], a_good[23:0]}, 73'(0));
`endif
        reset = 0;
        step();

        // Single-beat frame: tvalid must rise two cycles after the tlast beat.
        s_tdata = 64'h0123_4567_89AB_CDEF; s_tkeep = 8'h3F; s_tlast = 1; s_tuser = 0; s_tvalid = 1;
        step();
        s_tvalid = 0;
        check("lat0_tvalid", 73'(a_tvalid), 73'(0));
        step();
        check("lat1_tvalid", 73'(a_tvalid), 73'(0));
        step();
        check("lat2_tvalid", 73'(a_tvalid), 73'(1));
        check("lat2_word", {a_tlast, a_tkeep, a_tdata}, {1'b1, 8'h3F, 64'h0123_4567_89AB_CDEF});
        step();
        check("single_consumed", 73'(a_tvalid), 73'(0));
        exp_good = 1;
`ifdef RX_DROP_STATS_EN
        check("single_good_cnt", 73'(a_good), 73'(1));
`endif
        mon_en = 1;

        // Good / bad / good back-to-back.
        start = out_beats;
        send_frame(10, 0, 0);
        send_frame(10, 1, 0);
        send_frame(10, 0, 0);
        wait_drain(200);
        check("bgb_beats", 73'(out_beats - start), 73'(20));
        check("bgb_level", 73'(a_level), 73'(0));
`ifdef RX_DROP_STATS_EN
        check("bgb_bad_cnt", 73'(a_bad), 73'(exp_bad));
        check("bgb_good_cnt", 73'(a_good), 73'(exp_good));
`endif

        // Small FIFO fills under backpressure and drops the third frame.
        do_reset();
        m_tready = 0;
        b_track = 1; mon_b_en = 1; out_b = 0;
        send_frame(6, 0, 0);
        send_frame(6, 0, 0);
        send_frame(6, 0, 0);
        repeat (5) step();
        check("small_level", 73'(b_level), 73'(b_stored));
        check("small_level12", 73'(b_level), 73'(12));
        check("big_level", 73'(a_level), 73'(18));
`ifdef RX_DROP_STATS_EN
        check("small_ovf_cnt", 73'(b_ovf), 73'(exp_b_ovf));
        check("big_ovf_cnt", 73'(a_ovf), 73'(0));
`endif
        m_tready = 1;
        wait_drain(200);
        check("small_beats", 73'(out_b), 73'(12));
        check("small_level_end", 73'(b_level), 73'(0));
        b_track = 0; mon_b_en = 0;

        // Length boundaries: 200 and 191 dropped, 190 passes.
        start = out_beats;
        send_frame(200, 0, 0);
        send_frame(4, 0, 0);
        send_frame(190, 0, 0);
        send_frame(191, 0, 0);
        send_frame(3, 0, 0);
        wait_drain(1000);
        check("long_beats", 73'(out_beats - start), 73'(4 + 190 + 3));
        check("long_level", 73'(a_level), 73'(0));
`ifdef RX_DROP_STATS_EN
        check("long_ovf_cnt", 73'(a_ovf), 73'(exp_ovf));
        check("long_good_cnt", 73'(a_good), 73'(exp_good));
`endif

        // Random frames with random backpressure.
        rand_rdy = 1;
        for (int f = 0; f < 1000; f++) begin
            int len;
            len = ($urandom_range(0, 49) == 0) ? $urandom_range(185, 200) : $urandom_range(1, 16);
            send_frame(len, $urandom_range(0, 4) == 0, 60);
        end
        rand_rdy = 0;
        m_tready = 1;
        wait_drain(3000);
        check("rand_level", 73'(a_level), 73'(0));
`ifdef RX_DROP_STATS_EN
        check("rand_good_cnt", 73'(a_good), 73'(exp_good));
        check("rand_bad_cnt", 73'(a_bad), 73'(exp_bad));
        check("rand_ovf_cnt", 73'(a_ovf), 73'(exp_ovf));
`endif

        // Reset mid-frame discards committed and partial frames.
        m_tready = 0;
        send_frame(3, 0, 0);
        send_frame(3, 0, 0);
        s_tdata = 64'hDEAD_BEEF_0000_0001; s_tkeep = 8'hFF; s_tlast = 0; s_tuser = 0; s_tvalid = 1;
        step(); step();
        s_tvalid = 0;
        step(); step();
        check("pre_rst_tvalid", 73'(a_tvalid), 73'(1));
        check("pre_rst_level", 73'(a_level), 73'(6));
        mon_en = 0;
        reset = 1;
        step();
        check("mid_rst_tvalid", 73'(a_tvalid), 73'(0));
        check("mid_rst_level", 73'(a_level), 73'(0));
        reset = 0;
        clear_model();
        m_tready = 1;
        mon_en = 1;
        start = out_beats;
        repeat (10) step();
        check("post_rst_quiet", 73'(out_beats - start), 73'(0));
        send_frame(2, 0, 0);
        wait_drain(100);
        check("post_rst_beats", 73'(out_beats - start), 73'(2));
`ifdef RX_DROP_STATS_EN
        check("post_rst_good_cnt", 73'(a_good), 73'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_packet_drop_fifo.md
RX_PACKET_DROP_FIFO -- requirements
Module: rx_packet_drop_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, giving FIFO depth 2^DEPTH_LOG2 words of 64b data + 8b keep + 1b last.
REQ-002 SHALL have parameter MAX_FRAME_WORDS, default 190, giving the longest legal frame in 8-byte words.
REQ-003 clk156  in  1  sole clock, 156.25 MHz; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 s_axis_tdata/tkeep/tvalid/tlast/tuser  in  64/8/1/1/1  frame stream from the 10G MAC RX; tuser=1 on the tlast beat marks a bad frame.
REQ-006 s_axis_tready  out  1  constant 1; the MAC cannot be stalled.
REQ-007 m_axis_tdata/tkeep/tvalid/tlast  out  64/8/1/1  stream of good frames only.
REQ-008 m_axis_tready  in  1  downstream ready.
REQ-009 fifo_level  out  DEPTH_LOG2+1  committed words not yet read.
REQ-010 drop_bad_cnt, drop_ovf_cnt, good_cnt  out  32 each  statistics; present only with RX_DROP_STATS_EN.

Function
REQ-011 SHALL be store-and-forward: no beat of a frame appears on m_axis before that frame's tlast beat is written and committed.
REQ-012 Pointers wr_ptr (tentative), wr_commit and rd_ptr SHALL each be DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
REQ-013 Full SHALL be wr_ptr - rd_ptr == 2^DEPTH_LOG2; empty SHALL be rd_ptr == wr_commit.
REQ-014 The write FSM SHALL have states IDLE, WRITE, DROP.
REQ-015 IDLE: a valid beat SHALL be written at wr_ptr, and wr_ptr SHALL increment. Next state is WRITE if tlast=0; otherwise the tlast rules below apply.
REQ-016 WRITE: each valid beat SHALL be written and wr_ptr SHALL increment.
REQ-017 A tlast beat with tuser=0, when not full, SHALL set wr_commit to wr_ptr+1 and return the FSM to IDLE.
REQ-018 A tlast beat with tuser=1 SHALL set wr_ptr to wr_commit (rollback), increment drop_bad_cnt, and return the FSM to IDLE.
REQ-019 A beat arriving while full, or the word after MAX_FRAME_WORDS beats without tlast, SHALL roll wr_ptr back to wr_commit and increment drop_ovf_cnt. The FSM SHALL go to DROP, or to IDLE if that beat carries tlast.
REQ-020 DROP: beats SHALL be discarded until and including tlast, then the FSM returns to IDLE. tuser is ignored in DROP.
REQ-021 Full and tlast on the same beat SHALL count as overflow, not as bad; each dropped frame increments exactly one counter.
REQ-022 Storage SHALL be a RAM with 1-cycle read latency feeding a one-word output register (prefetch). With m_axis_tready=1, m_axis_tvalid SHALL rise exactly 2 cycles after the committing tlast beat when the FIFO was empty.
REQ-023 m_axis SHALL sustain one word per cycle while committed data exists and m_axis_tready=1.
REQ-024 m_axis_tdata/tkeep/tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-025 A simultaneous commit and read SHALL both take effect, with fifo_level updated by their net change.
REQ-026 good_cnt SHALL increment on each commit; counters SHALL saturate at 2^32-1.

Reset
REQ-027 On reset: all pointers 0, FSM IDLE, m_axis_tvalid 0, m_axis_tdata/tkeep/tlast 0, fifo_level 0, counters 0.
REQ-028 Reset mid-operation SHALL discard all stored and partial frames. The first valid beat after reset SHALL be treated as a frame start.

Configuration
REQ-029 Macro RX_DROP_STATS_EN: when defined, the three counters and their ports SHALL exist. When undefined, the ports and counter logic SHALL be absent; drop and commit behaviour SHALL be identical in both builds.

Structure
REQ-030 The shared package SHALL hold the FIFO word layout constants (data width 64, keep width 8, word width 73) and the FSM state encoding.
REQ-031 The RAM SHALL be one sub-module, rx_pkt_sdp_ram: simple dual-port, 1-cycle registered read, parameterised depth and width.

Verification
REQ-032 Single-beat good frame (tkeep=0x3F, tlast=1, tuser=0) with tready=1 -> identical beat on m_axis 2 cycles later; good_cnt=1.
REQ-033 Frames of 10 beats good, 10 beats tuser=1, 10 beats good, sent back-to-back -> exactly 20 beats out, in order; drop_bad_cnt=1; fifo_level returns to 0.
REQ-034 DEPTH_LOG2=4, m_axis_tready=0, 3 good frames of 6 beats each -> first 2 frames stored (fifo_level=12), third dropped, drop_ovf_cnt=1; then tready=1 -> 12 beats out.
REQ-035 Frame of 200 beats without tlast followed by a 4-beat good frame -> long frame dropped (drop_ovf_cnt=1); only the 4-beat frame is output.
REQ-036 Random tready toggling over 1000 random frames -> output equals the good-frame reference model; no beat changes while stalled.
REQ-037 Reset asserted mid-frame with 2 frames committed -> m_axis_tvalid=0 the next cycle; nothing output until a new frame commits.
